// File: rtl/rd_stream_u8.sv
// Sequential byte reader in front of the read cache: issues credit-limited reads,
// buffers returned bytes in a small FIFO and streams them out as valid/ready.
`timescale 1ns/1ps

module rd_stream_u8 #(
    parameter int DEPTH        = 4,
    parameter bit CLR_ON_START = 1'b1
) (
    input  logic        aclk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [31:0] rd_ofs,
    input  logic [23:0] rd_len,
    output logic        busy,
    output logic        done,
    output logic        clreq,
    output logic [31:0] adr,
    output logic        re,
    input  logic        rdy,
    input  logic [7:0]  dru8,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, CLR, RUN, DRAIN} state_t;

    state_t        state;
    logic [23:0]   len;
    logic [23:0]   issued;
    logic [23:0]   delivered;
    logic          inflight;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          credit;
    logic          accept;
    logic          push;
    logic          pop;

    // A slot is reserved for the read still in flight, so the FIFO cannot overflow.
    assign credit  = (count + CW'(inflight)) < DEPTH_C;
    assign re      = (state == RUN) && (issued != len) && credit;
    assign accept  = re && rdy;
    assign push    = inflight;
    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= dru8;
        end
    end

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            clreq     <= 1'b0;
            adr       <= '0;
            len       <= '0;
            issued    <= '0;
            delivered <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            done     <= 1'b0;
            clreq    <= 1'b0;
            inflight <= accept;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                delivered <= delivered + 24'd1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (accept) begin
                adr    <= adr + 32'd1;
                issued <= issued + 24'd1;
            end

            unique case (state)
                IDLE: begin
                    // A start coinciding with the done pulse belongs to the old job.
                    if (start && !done) begin
                        if (rd_len == 24'd0) begin
                            done <= 1'b1;
                        end else begin
                            adr       <= rd_ofs;
                            len       <= rd_len;
                            issued    <= '0;
                            delivered <= '0;
                            busy      <= 1'b1;
                            if (CLR_ON_START) begin
                                clreq <= 1'b1;
                                state <= CLR;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                end
                CLR: begin
                    state <= RUN;
                end
                RUN: begin
                    if (accept && (issued + 24'd1 == len)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (delivered + 24'd1 == len)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rd_stream_u8.sv
// Directed bench for rd_stream_u8: cache model returns adr[7:0] one cycle after an
// accepted read; a negedge monitor records the output stream and protocol events.
`timescale 1ns/1ps

module tb_rd_stream_u8;

    logic        aclk = 1'b0;
    logic        arst_n;
    logic        start;
    logic [31:0] rd_ofs;
    logic [23:0] rd_len;
    logic        busy;
    logic        done;
    logic        clreq;
    logic [31:0] adr;
    logic        re;
    logic        rdy;
    logic [7:0]  dru8 = 8'h00;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;

    int n_vec  = 0;
    int n_miss = 0;

    // cache stall injection
    logic [31:0] stall_adr = 32'hFFFF_FFFF;
    int          stall_total = 0;
    int          stall_seen = 0;

    // monitor state
    logic [7:0]  got [$];
    int          xcyc [$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          clreq_cnt = 0;
    int          re_cnt = 0;
    int          acc = 0;
    int          xfer = 0;
    int          max_out = 0;
    int          stall_cyc = 0;
    int          hold_err = 0;
    int          stall_err = 0;
    logic        prev_hold = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [31:0] prev_adr = 32'h0;

    always #5 aclk = ~aclk;

    rd_stream_u8 #(.DEPTH(4), .CLR_ON_START(1'b1)) dut (
        .aclk    (aclk),
        .arst_n  (arst_n),
        .start   (start),
        .rd_ofs  (rd_ofs),
        .rd_len  (rd_len),
        .busy    (busy),
        .done    (done),
        .clreq   (clreq),
        .adr     (adr),
        .re      (re),
        .rdy     (rdy),
        .dru8    (dru8),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    assign rdy = !(re && (adr == stall_adr) && (stall_seen < stall_total));

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (re && rdy) dru8 <= adr[7:0];
        if (re && !rdy) stall_seen <= stall_seen + 1;
    end

    always @(negedge aclk) begin
        if (!arst_n) begin
            prev_hold  <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            if (prev_hold && (m_valid !== 1'b1 || m_data !== prev_data)) hold_err <= hold_err + 1;
            if (prev_stall && (re !== 1'b1 || adr !== prev_adr)) stall_err <= stall_err + 1;
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                xcyc.push_back(cyc);
            end
            xfer      <= xfer + ((m_valid && m_ready) ? 1 : 0);
            acc       <= acc + ((re && rdy) ? 1 : 0);
            stall_cyc <= stall_cyc + ((re && !rdy) ? 1 : 0);
            clreq_cnt <= clreq_cnt + (clreq ? 1 : 0);
            re_cnt    <= re_cnt + (re ? 1 : 0);
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (acc - xfer > max_out) max_out <= acc - xfer;
            prev_hold  <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_stall <= re && !rdy;
            prev_adr   <= adr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int base, input int n);
        check({tag, "_count"}, got.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < got.size()) check($sformatf("%s[%0d]", tag, i), got[base + i], i);
        end
    endtask

    task automatic start_job(input logic [31:0] ofs, input logic [23:0] len);
        @(posedge aclk); #1;
        rd_ofs = ofs;
        rd_len = len;
        start  = 1'b1;
        @(posedge aclk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!done && n < budget);
        check({tag, "_done_seen"}, done, 1'b1);
    endtask

    task automatic wait_got(input string tag, input int target, input int budget);
        int n = 0;
        while (got.size() < target && n < budget) begin
            @(posedge aclk); #1;
            n++;
        end
        check({tag, "_progress"}, (got.size() >= target), 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    busy,    1'b0);
        check({tag, "_done"},    done,    1'b0);
        check({tag, "_clreq"},   clreq,   1'b0);
        check({tag, "_re"},      re,      1'b0);
        check({tag, "_adr"},     adr,     32'h0);
        check({tag, "_m_valid"}, m_valid, 1'b0);
    endtask

    initial begin
        int base, d0, c0, r0, s0;
        arst_n  = 1'b0;
        start   = 1'b0;
        rd_ofs  = 32'h0;
        rd_len  = 24'h0;
        m_ready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_reset_outputs("rst");
        @(posedge aclk); #1;
        arst_n = 1'b1;

        // basic 8-byte job at full throughput
        base = got.size(); d0 = done_cnt; c0 = clreq_cnt;
        start_job(32'h100, 24'd8);
        wait_done("j1", 60);
        check("j1_busy_at_done", busy, 1'b0);
        repeat (4) @(posedge aclk); #1;
        check_seq("j1", base, 8);
        check("j1_clreq", clreq_cnt - c0, 1);
        check("j1_done_cnt", done_cnt - d0, 1);
        if (got.size() >= base + 8) begin
            check("j1_back_to_back", xcyc[base + 7] - xcyc[base], 7);
            check("j1_done_timing", done_cyc, xcyc[base + 7] + 1);
        end

        // cache stall of 5 cycles on read 3
        base = got.size(); s0 = stall_cyc;
        stall_adr   = 32'h103;
        stall_total = stall_seen + 5;
        start_job(32'h100, 24'd16);
        wait_done("j2", 80);
        repeat (4) @(posedge aclk); #1;
        check_seq("j2", base, 16);
        check("j2_stall_cycles", stall_cyc - s0, 5);
        check("j2_stall_hold", stall_err, 0);

        // downstream backpressure for 10 cycles
        base = got.size();
        start_job(32'h200, 24'd12);
        wait_got("j3", base + 3, 40);
        m_ready = 1'b0;
        repeat (10) @(posedge aclk);
        @(negedge aclk);
        check("j3_re_dropped", re, 1'b0);
        check("j3_valid_held", m_valid, 1'b1);
        @(posedge aclk); #1;
        m_ready = 1'b1;
        wait_done("j3", 60);
        repeat (4) @(posedge aclk); #1;
        check_seq("j3", base, 12);
        check("j3_max_outstanding", max_out, 4);
        check("j3_data_hold", hold_err, 0);

        // zero-length job
        d0 = done_cnt; c0 = clreq_cnt; r0 = re_cnt;
        @(posedge aclk); #1;
        rd_ofs = 32'h700; rd_len = 24'd0; start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        @(negedge aclk);
        check("j4_done_next", done, 1'b1);
        check("j4_busy", busy, 1'b0);
        repeat (5) @(posedge aclk); #1;
        check("j4_done_cnt", done_cnt - d0, 1);
        check("j4_no_clreq", clreq_cnt - c0, 0);
        check("j4_no_read", re_cnt - r0, 0);

        // start while busy, and start on the done cycle
        base = got.size(); d0 = done_cnt;
        start_job(32'h300, 24'd8);
        repeat (2) @(posedge aclk); #1;
        check("j5_busy", busy, 1'b1);
        rd_ofs = 32'h0; rd_len = 24'd20; start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        wait_done("j5", 60);
        rd_ofs = 32'h0; rd_len = 24'd5; start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        r0 = re_cnt;
        repeat (6) @(posedge aclk); #1;
        check("j5_busy_after", busy, 1'b0);
        check("j5_no_restart", re_cnt - r0, 0);
        check_seq("j5", base, 8);
        check("j5_done_cnt", done_cnt - d0, 1);

        // reset in the middle of a 20-byte job, then a 4-byte job
        base = got.size(); d0 = done_cnt;
        start_job(32'h400, 24'd20);
        wait_got("j6", base + 5, 40);
        arst_n = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check_reset_outputs("j6_rst");
        @(posedge aclk); #1;
        arst_n = 1'b1;
        repeat (3) @(posedge aclk); #1;
        check("j6_no_done", done_cnt - d0, 0);
        base = got.size(); d0 = done_cnt;
        start_job(32'h500, 24'd4);
        wait_done("j7", 40);
        repeat (4) @(posedge aclk); #1;
        check_seq("j7", base, 4);
        check("j7_done_cnt", done_cnt - d0, 1);
        check("j7_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d vectors, expected completion", n_vec);
        $fatal(1);
    end

endmodule
